// File: rtl/universal_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : universal_register_pkg
//  Purpose  : Shared constants for the universal register: operation-select
//             width and the encoding of each operation on the mode input.
//  Revision : 1.0 - initial release
// ============================================================================
package universal_register_pkg;

  // Width of the mode operation-select field.
  localparam int MODE_W = 3;

  // Operation encodings driven on the mode input.
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage : universal_register_pkg
`default_nettype wire

// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
//  Module   : universal_register
//  Purpose  : WIDTH-bit register with hold, parallel load, serial shift,
//             rotate, increment and decrement, selected per clock by mode.
//  Revision : 1.0 - initial release
//
//  Parameters
//    WIDTH       register width in bits (2..32)
//    RESET_VALUE value of out while rst is high (truncated to WIDTH bits)
//
//  Ports
//    clk     in   1      rising-edge clock
//    rst     in   1      asynchronous active-high reset
//    en      in   1      clock enable; 0 holds all state
//    mode    in   3      operation select (see universal_register_pkg)
//    in      in   WIDTH  parallel load data
//    ser_in  in   1      fill bit for SHL / SHR
//    out     out  WIDTH  registered contents
//    carry   out  1      registered bit shifted/rotated out, or wrap flag
//    zero    out  1      combinational, high when out == 0
//    parity  out  1      registered XOR of out (only with the macro below)
//
//  Build option
//    UNIVERSAL_REGISTER_PARITY_EN  adds the registered parity output.
// ============================================================================
module universal_register
  import universal_register_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  in,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  out,
  output logic              carry,
  output logic              zero
`ifdef UNIVERSAL_REGISTER_PARITY_EN
  ,output logic             parity
`endif
);

  localparam logic [WIDTH-1:0] C_RESET = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic [WIDTH-1:0] w_next_out;
  logic             w_next_carry;

  // Next-state mux. Defaults hold, which also covers en=0 and MODE_HOLD.
  always_comb begin
    w_next_out   = r_out;
    w_next_carry = r_carry;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          w_next_out   = in;
          w_next_carry = 1'b0;
        end
        MODE_SHL: begin
          w_next_out   = {r_out[WIDTH-2:0], ser_in};
          w_next_carry = r_out[WIDTH-1];
        end
        MODE_SHR: begin
          w_next_out   = {ser_in, r_out[WIDTH-1:1]};
          w_next_carry = r_out[0];
        end
        MODE_ROL: begin
          w_next_out   = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
          w_next_carry = r_out[WIDTH-1];
        end
        MODE_ROR: begin
          w_next_out   = {r_out[0], r_out[WIDTH-1:1]};
          w_next_carry = r_out[0];
        end
        // Wrap flags come from the old value: all ones before INC, zero before DEC.
        MODE_INC: begin
          w_next_out   = r_out + C_ONE;
          w_next_carry = &r_out;
        end
        MODE_DEC: begin
          w_next_out   = r_out - C_ONE;
          w_next_carry = ~|r_out;
        end
        default: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= C_RESET;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_next_out;
      r_carry <= w_next_carry;
    end
  end

`ifdef UNIVERSAL_REGISTER_PARITY_EN
  // Parity is taken from the next value so it lines up with out on the same edge.
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= ^C_RESET;
    end else begin
      r_parity <= ^w_next_out;
    end
  end

  assign parity = r_parity;
`endif

  assign out   = r_out;
  assign carry = r_carry;
  assign zero  = ~|r_out;

endmodule : universal_register
`default_nettype wire
